// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W_DEF   = 11;
    localparam int unsigned INST_W_DEF = 16;

    localparam logic [3:0]  OP_HALT  = 4'hF;
    localparam logic [15:0] NOP_INST = 16'h0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection: redirect, hold (stall/halt/non-RUN) or increment.
module pc_sel
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic            branch_take,
    input  logic [PC_W-1:0] branch_target,
    input  logic            stall,
    input  logic            halt_hit,
    input  fetch_state_t    state,
    output logic [PC_W-1:0] next_pc
);

    always_comb begin
        next_pc = pc;
        if (state == RUN) begin
            if (branch_take)
                next_pc = branch_target;
            else if (!stall && !halt_hit)
                next_pc = pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, IF/ID instruction register, stall/redirect/halt control.
// Optional FETCH_COUNT_EN adds a saturating issued-word counter on port fetch_count.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = PC_W_DEF,
    parameter int unsigned     INST_W   = INST_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_take,
    input  logic [PC_W-1:0]   branch_target,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic              inst_valid,
    output logic              halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, next_pc;
    logic            halt_hit;
    logic            issue;

    assign imem_addr = pc_q;
    assign halt_hit  = (state_q == RUN) && (imem_data[INST_W-1 -: 4] == OP_HALT);
    // A word is issued only in RUN with neither redirect nor stall pending.
    assign issue     = (state_q == RUN) && !branch_take && !stall;

    pc_sel #(.PC_W(PC_W)) u_pc_sel (
        .pc            (pc_q),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .stall         (stall),
        .halt_hit      (halt_hit),
        .state         (state_q),
        .next_pc       (next_pc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (issue && halt_hit) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= BOOT;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            inst_out   <= '0;
            pc_out     <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            pc_q <= next_pc;
            case (state_q)
                RUN: begin
                    if (branch_take) begin
                        inst_out   <= INST_W'(NOP_INST);
                        inst_valid <= 1'b0;
                    end else if (issue) begin
                        inst_out   <= imem_data;
                        pc_out     <= pc_q;
                        inst_valid <= 1'b1;
                        if (halt_hit)
                            halted <= 1'b1;
                    end
                end
                HALT:    inst_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else if (issue && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven, scoreboarded bench for fetch_unit with a combinational instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_take;
    logic [10:0] branch_target;
    logic [10:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] inst_out;
    logic [10:0] pc_out;
    logic        inst_valid;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    logic [15:0] mem [0:2047];
    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(11), .INST_W(16), .RESET_PC(11'd0)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_take   (branch_take),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .inst_valid    (inst_valid),
        .halted        (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [10:0] tgt;
        logic [15:0] inst;
        logic [10:0] pc;
        logic        valid;
        logic        halted;
        logic [10:0] addr;
        logic [15:0] cnt;
    } row_t;

    row_t rows [27];
    row_t sb [$];
    int   errors = 0;
    int   checks = 0;

    function automatic row_t mk(input logic s, input logic b, input logic [10:0] t,
                                input logic [15:0] i, input logic [10:0] p, input logic v,
                                input logic h, input logic [10:0] a, input logic [15:0] c);
        row_t r;
        r.stall = s; r.br = b; r.tgt = t; r.inst = i; r.pc = p;
        r.valid = v; r.halted = h; r.addr = a; r.cnt = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic apply_row(input int idx);
        row_t e;
        @(negedge clk);
        stall         = rows[idx].stall;
        branch_take   = rows[idx].br;
        branch_target = rows[idx].tgt;
        sb.push_back(rows[idx]);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("row%0d_scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("row%0d_inst_out", idx),   32'(inst_out),   32'(e.inst));
            chk($sformatf("row%0d_pc_out", idx),     32'(pc_out),     32'(e.pc));
            chk($sformatf("row%0d_inst_valid", idx), 32'(inst_valid), 32'(e.valid));
            chk($sformatf("row%0d_halted", idx),     32'(halted),     32'(e.halted));
            chk($sformatf("row%0d_imem_addr", idx),  32'(imem_addr),  32'(e.addr));
`ifdef FETCH_COUNT_EN
            chk($sformatf("row%0d_fetch_count", idx), 32'(fetch_count), 32'(e.cnt));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'(32'h1000 + i);
        mem[0] = 16'h1234;
        mem[1] = 16'h2345;

        //                 stall br  tgt       inst      pc       v  h  addr     cnt
        rows[0]  = mk(0, 0, 11'h000, 16'h0000, 11'd0,    0, 0, 11'd0,    16'd0);
        rows[1]  = mk(0, 0, 11'h000, 16'h1234, 11'd0,    1, 0, 11'd1,    16'd1);
        rows[2]  = mk(0, 0, 11'h000, 16'h2345, 11'd1,    1, 0, 11'd2,    16'd2);
        rows[3]  = mk(0, 0, 11'h000, 16'h1002, 11'd2,    1, 0, 11'd3,    16'd3);
        rows[4]  = mk(0, 0, 11'h000, 16'h1003, 11'd3,    1, 0, 11'd4,    16'd4);
        rows[5]  = mk(0, 0, 11'h000, 16'h1004, 11'd4,    1, 0, 11'd5,    16'd5);
        rows[6]  = mk(1, 0, 11'h000, 16'h1004, 11'd4,    1, 0, 11'd5,    16'd5);
        rows[7]  = mk(1, 0, 11'h000, 16'h1004, 11'd4,    1, 0, 11'd5,    16'd5);
        rows[8]  = mk(1, 0, 11'h000, 16'h1004, 11'd4,    1, 0, 11'd5,    16'd5);
        rows[9]  = mk(0, 0, 11'h000, 16'h1005, 11'd5,    1, 0, 11'd6,    16'd6);
        rows[10] = mk(0, 0, 11'h000, 16'h1006, 11'd6,    1, 0, 11'd7,    16'd7);
        rows[11] = mk(1, 1, 11'h100, 16'h0000, 11'd6,    0, 0, 11'h100,  16'd7);
        rows[12] = mk(0, 0, 11'h000, 16'h1100, 11'h100,  1, 0, 11'h101,  16'd8);
        rows[13] = mk(0, 1, 11'h7FE, 16'h0000, 11'h100,  0, 0, 11'h7FE,  16'd8);
        rows[14] = mk(0, 0, 11'h000, 16'h17FE, 11'h7FE,  1, 0, 11'h7FF,  16'd9);
        rows[15] = mk(0, 0, 11'h000, 16'h17FF, 11'h7FF,  1, 0, 11'h000,  16'd10);
        rows[16] = mk(0, 0, 11'h000, 16'h1234, 11'd0,    1, 0, 11'd1,    16'd11);
        rows[17] = mk(0, 0, 11'h000, 16'h2345, 11'd1,    1, 0, 11'd2,    16'd12);
        rows[18] = mk(1, 0, 11'h000, 16'h2345, 11'd1,    1, 0, 11'd2,    16'd12);
        rows[19] = mk(0, 1, 11'h200, 16'h0000, 11'd0,    0, 0, 11'd0,    16'd0);
        rows[20] = mk(0, 0, 11'h000, 16'h1234, 11'd0,    1, 0, 11'd1,    16'd1);
        rows[21] = mk(0, 0, 11'h000, 16'h2345, 11'd1,    1, 0, 11'd2,    16'd2);
        rows[22] = mk(0, 0, 11'h000, 16'h1002, 11'd2,    1, 0, 11'd3,    16'd3);
        rows[23] = mk(0, 0, 11'h000, 16'hF000, 11'd3,    1, 1, 11'd3,    16'd4);
        rows[24] = mk(0, 1, 11'h050, 16'hF000, 11'd3,    0, 1, 11'd3,    16'd4);
        rows[25] = mk(1, 0, 11'h000, 16'hF000, 11'd3,    0, 1, 11'd3,    16'd4);
        rows[26] = mk(0, 0, 11'h000, 16'hF000, 11'd3,    0, 1, 11'd3,    16'd4);

        reset = 1'b0; stall = 1'b0; branch_take = 1'b0; branch_target = '0;
        repeat (3) @(posedge clk);
        release_reset();
        for (int i = 0; i <= 18; i++) apply_row(i);

        // Asynchronous reset while stalled: outputs clear before any clock edge.
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_inst_out",   32'(inst_out),   32'h0);
        chk("async_pc_out",     32'(pc_out),     32'h0);
        chk("async_inst_valid", 32'(inst_valid), 32'h0);
        chk("async_halted",     32'(halted),     32'h0);
        chk("async_imem_addr",  32'(imem_addr),  32'h0);
`ifdef FETCH_COUNT_EN
        chk("async_fetch_count", 32'(fetch_count), 32'h0);
`endif
        stall = 1'b0;
        mem[3] = 16'hF000;
        release_reset();
        for (int i = 19; i <= 26; i++) apply_row(i);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the decoder / register file / ALU path.
- Owns the program counter and drives the address of the combinational instruction memory.
- Registers the returned 16-bit word into an IF/ID instruction register and presents it to the decoder.
- Adds stall, branch redirect with flush, and a halt state on top of the plain free-running counter.

Parameters:
- PC_W, 11, program counter / instruction-memory address width.
- INST_W, 16, instruction width; opcode is bits [INST_W-1:INST_W-4].
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- stall  in  1  hold PC and instruction register this cycle.
- branch_take  in  1  redirect fetch to branch_target this cycle.
- branch_target  in  PC_W  redirect address.
- imem_addr  out  PC_W  address to instruction memory; equals the internal PC (combinational).
- imem_data  in  INST_W  instruction word returned combinationally for imem_addr.
- inst_out  out  INST_W  registered instruction to the decoder.
- pc_out  out  PC_W  address the current inst_out was fetched from.
- inst_valid  out  1  inst_out holds a real instruction (not a bubble).
- halted  out  1  fetch has stopped on a HALT opcode.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, inst_out=16'h0000, pc_out=0, inst_valid=0, halted=0, state=BOOT.
  - Mid-operation reset aborts any pending branch or stall immediately.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts exactly one clk after reset deasserts; outputs hold reset values. Next state is RUN unconditionally; stall and branch are ignored.
- RUN, per rising edge, highest priority first:
  1. branch_take=1: pc<=branch_target, inst_out<=16'h0000, inst_valid<=0. Flush wins over stall; the in-flight word is discarded.
  2. stall=1: pc, inst_out, pc_out and inst_valid all hold.
  3. Otherwise: inst_out<=imem_data, pc_out<=pc, inst_valid<=1, pc<=pc+1 mod 2^PC_W (2047 wraps to 0).
  4. If case 3 applies and imem_data opcode == OP_HALT (4'hF): the word is still issued (inst_valid<=1), pc is NOT incremented, halted<=1, state<=HALT.
- HALT:
  - Next cycle inst_valid<=0; inst_out, pc_out and pc hold.
  - halted stays 1; stall and branch_take are ignored; only reset leaves HALT.
- Latency: a word at address A appears on inst_out one clk after imem_addr==A, provided there is no stall.
- A redirect costs one bubble cycle.

Optional Feature:
- Macro: FETCH_COUNT_EN.
- When defined:
  - Extra output port fetch_count, 16 bits.
  - Increments on every edge where inst_valid is loaded with 1, including the HALT word.
  - Saturates at 16'hFFFF; cleared by reset.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - OP_HALT=4'hF
  - NOP_INST=16'h0000
  - state encoding BOOT=2'd0, RUN=2'd1, HALT=2'd2
  - default widths
- One sub-module, pc_sel: combinational next-PC mux. Inputs: pc, branch_take, branch_target, stall, halt_hit, state. Output: next_pc.

Test Plan:
- Reset release, imem holding 16'h1234 at 0 and 16'h2345 at 1 -> BOOT cycle with inst_valid=0; then inst_out=1234, pc_out=0; next cycle inst_out=2345, pc_out=1.
- stall high 3 cycles while pc=5 -> imem_addr stays 5, inst_out/pc_out/inst_valid unchanged for 3 cycles; resumes at 5 on release.
- branch_take=1, target=11'h100, stall also 1 at pc=7 -> next cycle imem_addr=0x100, inst_valid=0, inst_out=0000; following cycle inst_out=mem[0x100], pc_out=0x100.
- Sequential run from pc=2046 -> pc_out sequence 2046, 2047, 0, 1 with inst_valid=1 throughout.
- mem[3]=16'hF000 -> inst_out=F000 with inst_valid=1 and halted=1; from the next cycle inst_valid=0 and imem_addr stays 3; branch_take pulse has no effect.
- reset pulled low asynchronously mid-stall -> all outputs zero before the next edge; FETCH_COUNT_EN build: fetch_count=0, and after 4 issued words fetch_count=4.
